// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: validates and commits received frames as the active
// command set, runs the link watchdog with explicit re-arm, and issues the
// feedback snapshot strobe at the start of each transfer.
//
// Handshake: frame_start and frame_valid are single-cycle strobes with no
// back-pressure. frame_data is sampled only in the cycle frame_valid is high,
// so each pulse can commit at most once. Every effect of a frame_valid in
// cycle N appears on the outputs in cycle N+1.
module spi_frame_ctrl #(
  parameter int          FRAME_W    = 400,
  parameter logic [31:0] HEADER_RX  = 32'h74697277,
  parameter int          NJOINTS    = 8,
  parameter int          EN_LSB     = 8,
  parameter int          WDT_CYCLES = 5000000
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic [FRAME_W-1:0] cmd_data,
  output logic               cmd_update,
  output logic [NJOINTS-1:0] joint_enable,
  output logic               outputs_safe,
  output logic               snap_req,
  output logic [1:0]         state,
  output logic [15:0]        err_count
);

  localparam logic [1:0]  ST_IDLE    = 2'b00;
  localparam logic [1:0]  ST_RUN     = 2'b01;
  localparam logic [1:0]  ST_TIMEOUT = 2'b10;
  localparam logic [31:0] WDT_LOAD   = 32'(WDT_CYCLES - 1);

  logic [1:0]         state_d;
  logic [31:0]        wdt;
  logic               hdr_ok;
  logic               good;
  logic               bad;
  logic               en0;
  logic               wdt_zero;
  logic               do_commit;
  logic               do_timeout;
  logic [NJOINTS-1:0] en_rev;

  assign hdr_ok   = (frame_data[FRAME_W-1 -: 32] == HEADER_RX);
  assign good     = frame_valid & hdr_ok;
  assign bad      = frame_valid & ~hdr_ok;
  assign en0      = (frame_data[EN_LSB +: NJOINTS] == '0);
  assign wdt_zero = (wdt == 32'd0);

  // Joint enable bit i comes from the mirrored position in the enable field.
  always_comb begin
    en_rev = '0;
    for (int i = 0; i < NJOINTS; i++) begin
      en_rev[i] = frame_data[EN_LSB + NJOINTS - 1 - i];
    end
  end

  // State register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; a good frame always beats an expiring watchdog.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (good) state_d = ST_RUN;
      ST_RUN:     if (!good && wdt_zero) state_d = ST_TIMEOUT;
      ST_TIMEOUT: if (good && en0) state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Action decode: when to commit a frame and when to force the safe command set.
  always_comb begin
    do_commit  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ST_IDLE:    do_commit = good;
      ST_RUN: begin
        do_commit  = good;
        do_timeout = !good && wdt_zero;
      end
      ST_TIMEOUT: do_commit = good && en0;
      default: begin
        do_commit  = 1'b0;
        do_timeout = 1'b0;
      end
    endcase
  end

  // Command set register: atomic load on commit, zeroed on watchdog expiry.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cmd_data     <= '0;
      cmd_update   <= 1'b0;
      joint_enable <= '0;
      outputs_safe <= 1'b1;
    end else begin
      cmd_update <= 1'b0;
      if (do_commit) begin
        cmd_data     <= frame_data;
        cmd_update   <= 1'b1;
        joint_enable <= en_rev;
        outputs_safe <= 1'b0;
      end else if (do_timeout) begin
        cmd_data     <= '0;
        cmd_update   <= 1'b1;
        joint_enable <= '0;
        outputs_safe <= 1'b1;
      end
    end
  end

  // Link watchdog: reloaded on commit, counts down only while running, holds at zero.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst)                              wdt <= 32'd0;
    else if (do_commit)                   wdt <= WDT_LOAD;
    else if (state == ST_RUN && !wdt_zero) wdt <= wdt - 32'd1;
  end

  // Bad-header counter, saturating.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst)                         err_count <= 16'd0;
    else if (bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end

  // Snapshot strobe trails the transfer-start pulse by one cycle in every state.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) snap_req <= 1'b0;
    else     snap_req <= frame_start;
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Testbench for spi_frame_ctrl: randomized frames driven against a
// deadline-based reference model, with a decoupled scoreboard/monitor.
module tb_spi_frame_ctrl;

  localparam int          FRAME_W = 400;
  localparam int          NJ      = 8;
  localparam int          EN_LSB  = 8;
  localparam int          WDT     = 16;
  localparam logic [31:0] HDR     = 32'h74697277;

  typedef struct packed {
    logic [FRAME_W-1:0] cmd;
    logic [1:0]         st;
    logic [15:0]        err;
    logic [NJ-1:0]      en;
    logic               safe;
    logic               snap;
    logic               upd;
  } stat_t;

  logic               sysclk;
  logic               rst;
  logic               frame_start;
  logic               frame_valid;
  logic [FRAME_W-1:0] frame_data;
  logic [FRAME_W-1:0] cmd_data;
  logic               cmd_update;
  logic [NJ-1:0]      joint_enable;
  logic               outputs_safe;
  logic               snap_req;
  logic [1:0]         state;
  logic [15:0]        err_count;

  spi_frame_ctrl #(
    .FRAME_W(FRAME_W), .HEADER_RX(HDR), .NJOINTS(NJ), .EN_LSB(EN_LSB), .WDT_CYCLES(WDT)
  ) dut (
    .sysclk(sysclk), .rst(rst), .frame_start(frame_start), .frame_valid(frame_valid),
    .frame_data(frame_data), .cmd_data(cmd_data), .cmd_update(cmd_update),
    .joint_enable(joint_enable), .outputs_safe(outputs_safe), .snap_req(snap_req),
    .state(state), .err_count(err_count)
  );

  // ---------------- clock ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  logic [FRAME_W-1:0] exp_q[$];
  stat_t              st_q[$];

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 timeout. Watchdog kept as an absolute deadline cycle.
  int                 m_mode;
  logic [FRAME_W-1:0] m_cmd;
  logic [NJ-1:0]      m_en;
  int                 m_err;
  int                 m_deadline;

  task automatic model_reset();
    m_mode = 0; m_cmd = '0; m_en = '0; m_err = 0; m_deadline = 0;
    exp_q.delete();
    st_q.delete();
  endtask

  task automatic check(input string name, input logic [FRAME_W-1:0] got, input logic [FRAME_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [31:0] hdr, input logic [NJ-1:0] en);
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < FRAME_W; i++) f[i] = 1'($urandom_range(0, 1));
    f[FRAME_W-1 -: 32] = hdr;
    f[EN_LSB +: NJ]    = en;
    return f;
  endfunction

  function automatic logic [31:0] bad_hdr();
    logic [31:0] h;
    h = $urandom;
    if (h == HDR) h = h ^ 32'h1;
    return h;
  endfunction

  // Driver: called at a falling edge; applies one cycle of inputs, advances the model.
  task automatic drive_cycle(input logic fs, input logic fv, input logic [FRAME_W-1:0] d);
    logic  good, en0, commit, tmo;
    stat_t s;
    frame_start = fs;
    frame_valid = fv;
    frame_data  = d;
    good   = fv && (d[FRAME_W-1 -: 32] == HDR);
    en0    = (d[EN_LSB +: NJ] == '0);
    commit = 1'b0;
    tmo    = 1'b0;
    if (fv && !good) m_err = (m_err >= 65535) ? 65535 : m_err + 1;
    case (m_mode)
      0: commit = good;
      1: begin
        if (good) commit = 1'b1;
        else if (cyc >= m_deadline) tmo = 1'b1;
      end
      default: commit = good && en0;
    endcase
    if (commit) begin
      m_cmd = d;
      for (int i = 0; i < NJ; i++) m_en[i] = d[EN_LSB + NJ - 1 - i];
      m_mode     = 1;
      m_deadline = cyc + WDT;
      exp_q.push_back(d);
    end else if (tmo) begin
      m_cmd  = '0;
      m_en   = '0;
      m_mode = 2;
      exp_q.push_back('0);
    end
    s.cmd  = m_cmd;
    s.st   = (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b10 : 2'b00;
    s.err  = 16'(m_err);
    s.en   = m_en;
    s.safe = (m_mode != 1);
    s.snap = fs;
    s.upd  = commit || tmo;
    st_q.push_back(s);
    cyc++;
    @(negedge sysclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, mk_frame(HDR, 8'hFF));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_data"},     cmd_data, '0);
    check({tag, "_cmd_update"},   FRAME_W'(cmd_update), '0);
    check({tag, "_joint_enable"}, FRAME_W'(joint_enable), '0);
    check({tag, "_outputs_safe"}, FRAME_W'(outputs_safe), FRAME_W'(1));
    check({tag, "_snap_req"},     FRAME_W'(snap_req), '0);
    check({tag, "_state"},        FRAME_W'(state), '0);
    check({tag, "_err_count"},    FRAME_W'(err_count), '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Samples one time unit after each rising edge.
  always begin
    stat_t e;
    @(posedge sysclk);
    #1;
    if (mon_en) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL status_underflow at %0t", $time);
      end else begin
        e = st_q.pop_front();
        checks++;
        if ({state, err_count, joint_enable, outputs_safe, snap_req, cmd_update} !==
            {e.st, e.err, e.en, e.safe, e.snap, e.upd}) begin
          errors++;
          $display("FAIL status t=%0t got st=%0h err=%0h en=%0h safe=%0b snap=%0b upd=%0b exp st=%0h err=%0h en=%0h safe=%0b snap=%0b upd=%0b",
                   $time, state, err_count, joint_enable, outputs_safe, snap_req, cmd_update,
                   e.st, e.err, e.en, e.safe, e.snap, e.upd);
        end
        check("cmd_hold", cmd_data, e.cmd);
      end
      if (cmd_update) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_update_unexpected got %0h exp none", cmd_data);
        end else begin
          check("cmd_update_data", cmd_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- global time bound ----------------
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL sim_timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time bound expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [FRAME_W-1:0] base;
    logic               fv;
    logic [31:0]        h;
    logic [NJ-1:0]      en;

    rst = 1'b1; frame_start = 1'b0; frame_valid = 1'b0; frame_data = '0;
    model_reset();
    repeat (2) @(negedge sysclk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // idle with snapshot pulses
    for (int i = 0; i < 4; i++) drive_cycle(1'(i[0]), 1'b0, mk_frame(HDR, 8'h00));
    // bad header in IDLE, then first good frame together with frame_start
    drive_cycle(1'b0, 1'b1, mk_frame(32'h0, 8'h11));
    drive_cycle(1'b1, 1'b1, mk_frame(HDR, 8'hA5));
    idle(3);
    // bad header in RUN
    drive_cycle(1'b0, 1'b1, mk_frame(32'h0000_0000, 8'h3C));
    idle(3);
    // another good commit with asymmetric enables
    drive_cycle(1'b0, 1'b1, mk_frame(HDR, 8'h01));
    // silence past the watchdog
    idle(WDT + 4);
    // re-arm rules in TIMEOUT
    drive_cycle(1'b0, 1'b1, mk_frame(HDR, 8'h01));
    idle(2);
    drive_cycle(1'b0, 1'b1, mk_frame(HDR, 8'h00));
    // good frame exactly on the expiry cycle
    idle(WDT - 1);
    drive_cycle(1'b0, 1'b1, mk_frame(HDR, 8'hC3));
    idle(WDT - 1);
    drive_cycle(1'b0, 1'b1, mk_frame(HDR, 8'h5A));
    idle(WDT + 3);
    drive_cycle(1'b0, 1'b1, mk_frame(HDR, 8'h00));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      fv = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 3) != 0) ? HDR : bad_hdr();
      en = ($urandom_range(0, 2) == 0) ? '0 : NJ'($urandom);
      drive_cycle(1'($urandom_range(0, 1)), fv, mk_frame(h, en));
    end

    // error counter saturation
    base = mk_frame(HDR, 8'h00);
    for (int i = 0; i < 65540; i++) begin
      base[FRAME_W-1 -: 32] = bad_hdr();
      drive_cycle(1'($urandom_range(0, 1)), 1'b1, base);
    end
    idle(2);

    // asynchronous reset in the middle of RUN
    drive_cycle(1'b0, 1'b1, mk_frame(HDR, 8'h00));
    idle(3);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge sysclk);
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    idle(1);
    drive_cycle(1'b1, 1'b0, mk_frame(HDR, 8'h00));
    idle(3);

    mon_en = 1'b0;
    check("status_queue_empty", FRAME_W'(st_q.size()), '0);
    check("cmd_queue_empty", FRAME_W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
